multi_cycle_ctrl: RTL



---
 rtl/cpu_pkg.sv | 69 ++++++
 rtl/multi_cycle_ctrl_decode.sv | 88 ++++++++
 rtl/multi_cycle_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: opcode constants, the
// multi-cycle controller state encoding, ALU operation / operand-select /
// PC-source encodings and the bundled control-word struct.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Multi-cycle controller states; codes 11..14 are deliberately unused
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_TRAP   = 4'd15
    } state_t;

    // ALU operation requested from ALU control
    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word produced by the state decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_wr;
        logic       reg_dst;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_decode
// Purely combinational state-to-control decoder for the multi-cycle
// controller. Outputs are a function of the current state only, except the
// FETCH-phase IR/PC load strobes, which additionally wait for the memory to
// complete the instruction read.
// Ports:
//   i_state      current controller state
//   i_mem_ready  memory completes the current access this cycle
//   o_ctrl       bundled control word
// -----------------------------------------------------------------------------
module multi_cycle_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            ST_FETCH: begin
                // Read instruction at PC and compute PC+4 in parallel; the
                // IR and PC only load once the read actually completes.
                o_ctrl.mem_rd    = 1'b1;
                o_ctrl.i_or_d    = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_rd = 1'b1;
                o_ctrl.i_or_d = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_wr     = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                // Held for the whole wait; memory commits on its ready cycle
                o_ctrl.mem_wr = 1'b1;
                o_ctrl.i_or_d = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.reg_wr     = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            ST_TRAP: begin
                o_ctrl.illegal = 1'b1;
            end
            default: o_ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Main control FSM of the multi-cycle CPU. Sequences the shared ALU, the
// unified instruction/data memory port and the register file over several
// cycles per instruction (R-type, lw, sw, beq, j), waits on MemReady in every
// memory state and traps on unknown opcodes.
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   OPCode        IR[31:26], looked at only in DECODE and MEMADR
//   MemReady      memory completes the current access this cycle
//   PCWrite .. RegDst  datapath control strobes / selects
//   Illegal       set while trapped; only reset leaves the trap
//   State         current state code (debug)
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOP,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWr,
    output logic       RegDst,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t r_state;
    state_t w_state_next;
    ctrl_t  w_ctrl;

    // State register. Outputs are decoded from this register, so a reset
    // edge removes any pending write strobe from the very next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (OPCode)
                    OP_LW, OP_SW: w_state_next = ST_MEMADR;
                    OP_RTYPE:     w_state_next = ST_EXEC;
                    OP_BEQ:       w_state_next = ST_BRANCH;
                    OP_J:         w_state_next = ST_JUMP;
                    default:      w_state_next = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                // The opcode is re-examined here; anything that is no longer
                // a memory instruction is treated as illegal.
                case (OPCode)
                    OP_LW:   w_state_next = ST_MEMRD;
                    OP_SW:   w_state_next = ST_MEMWR;
                    default: w_state_next = ST_TRAP;
                endcase
            end
            ST_MEMRD:  w_state_next = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_state_next = ST_FETCH;
            ST_MEMWR:  w_state_next = MemReady ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_state_next = ST_ALUWB;
            ST_ALUWB:  w_state_next = ST_FETCH;
            ST_BRANCH: w_state_next = ST_FETCH;
            ST_JUMP:   w_state_next = ST_FETCH;
            // TRAP is absorbing, which is what makes Illegal sticky
            ST_TRAP:   w_state_next = ST_TRAP;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Output decode
    multi_cycle_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .o_ctrl      (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.i_or_d;
    assign MemRd       = w_ctrl.mem_rd;
    assign MemWr       = w_ctrl.mem_wr;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUOP       = w_ctrl.alu_op;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign RegWr       = w_ctrl.reg_wr;
    assign RegDst      = w_ctrl.reg_dst;
    assign Illegal     = w_ctrl.illegal;
    assign State       = r_state;

endmodule
